fixed_point_div_seq: RTL and testbench

FIXED_POINT_DIV_SEQ -- requirements
Module: fixed_point_div_seq

---
 rtl/fixed_point_div_pkg.sv | 20 ++
 rtl/fixed_point_saturate.sv | 29 ++
 rtl/fixed_point_div_seq.sv | 159 +++++++++++++++
 tb/tb_fixed_point_div_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/fixed_point_div_pkg.sv
// Shared types and dimension helpers for the sequential fixed-point divider.
package fixed_point_div_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StDivide = 2'd1,
    StDone   = 2'd2
  } div_state_e;

  // Left shift applied to |A| so the integer quotient lands on Q_FRAC_BITS.
  function automatic int div_shift(input int q_frac, input int b_frac, input int a_frac);
    return q_frac + b_frac - a_frac;
  endfunction

  // Quotient bits produced by the long division.
  function automatic int div_len(input int a_width, input int shift);
    return a_width + shift;
  endfunction

endpackage

// File: rtl/fixed_point_saturate.sv
// Clamps an unsigned quotient magnitude plus sign into a signed Q_WIDTH result.
module fixed_point_saturate #(
  parameter int MAG_W   = 30,
  parameter int Q_WIDTH = 16
) (
  input  logic [MAG_W-1:0]   mag,
  input  logic               neg,
  output logic [Q_WIDTH-1:0] q,
  output logic               overflow
);

  // Extra headroom keeps the compare exact whether MAG_W is wider or narrower than Q_WIDTH.
  localparam int EXT_W = ((MAG_W > Q_WIDTH) ? MAG_W : Q_WIDTH) + 1;
  localparam logic [EXT_W-1:0] POS_LIM = (EXT_W'(1) << (Q_WIDTH - 1)) - EXT_W'(1);
  localparam logic [EXT_W-1:0] NEG_LIM = EXT_W'(1) << (Q_WIDTH - 1);

  logic [EXT_W-1:0] mag_ext;

  always_comb begin
    mag_ext  = EXT_W'(mag);
    overflow = neg ? (mag_ext > NEG_LIM) : (mag_ext > POS_LIM);
    if (overflow) begin
      q = neg ? {1'b1, {(Q_WIDTH - 1){1'b0}}} : {1'b0, {(Q_WIDTH - 1){1'b1}}};
    end else begin
      q = neg ? -mag_ext[Q_WIDTH-1:0] : mag_ext[Q_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_point_div_seq.sv
// Sequential signed fixed-point divider, one restoring-division bit per cycle.
// Define FIXED_POINT_DIV_ROUND_EN for round-half-away-from-zero (one extra iteration).
module fixed_point_div_seq
  import fixed_point_div_pkg::*;
#(
  parameter int A_WIDTH     = 16,
  parameter int A_FRAC_BITS = 14,
  parameter int B_WIDTH     = 16,
  parameter int B_FRAC_BITS = 14,
  parameter int Q_WIDTH     = 16,
  parameter int Q_FRAC_BITS = 14
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [A_WIDTH-1:0] A,
  input  logic [B_WIDTH-1:0] B,
  output logic               valid_out,
  input  logic               ready_in,
  output logic [Q_WIDTH-1:0] Q,
  output logic               div_by_zero_out,
  output logic               overflow_out
);

  localparam int S = div_shift(Q_FRAC_BITS, B_FRAC_BITS, A_FRAC_BITS);
  localparam int N = div_len(A_WIDTH, S);
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif
  localparam int ITER  = N + RND;
  localparam int CNT_W = $clog2(ITER + 1);

  if (S < 0) begin : g_bad_shift
    $error("fixed_point_div_seq: Q_FRAC_BITS + B_FRAC_BITS - A_FRAC_BITS must be >= 0");
  end

  div_state_e         state_q, state_d;
  logic [ITER-1:0]    quo_q, quo_d;
  logic [B_WIDTH:0]   rem_q, rem_d;
  logic [B_WIDTH:0]   div_q, div_d;
  logic               sign_q, sign_d;
  logic               dbz_q, dbz_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [A_WIDTH:0]   a_mag;
  logic [B_WIDTH:0]   b_mag;
  logic [ITER-1:0]    num_load;
  logic [B_WIDTH+1:0] trial;
  logic [ITER-1:0]    mag;
  logic [Q_WIDTH-1:0] sat_q;
  logic               sat_ovf;

  // One extra magnitude bit keeps the most negative operand exact.
  always_comb begin
    a_mag    = A[A_WIDTH-1] ? -{A[A_WIDTH-1], A} : {A[A_WIDTH-1], A};
    b_mag    = B[B_WIDTH-1] ? -{B[B_WIDTH-1], B} : {B[B_WIDTH-1], B};
    num_load = ITER'(a_mag) << (S + RND);
    trial    = {rem_q, quo_q[ITER-1]} - {1'b0, div_q};
  end

  // quo_q holds the unconsumed numerator bits on the left and quotient bits on the right.
  always_comb begin
    state_d = state_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    div_d   = div_q;
    sign_d  = sign_q;
    dbz_d   = dbz_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (valid_in) begin
          quo_d   = num_load;
          rem_d   = '0;
          div_d   = b_mag;
          sign_d  = A[A_WIDTH-1] ^ B[B_WIDTH-1];
          dbz_d   = (B == '0);
          cnt_d   = CNT_W'(ITER - 1);
          state_d = (B == '0) ? StDone : StDivide;
        end
      end
      StDivide: begin
        rem_d = trial[B_WIDTH+1] ? {rem_q[B_WIDTH-1:0], quo_q[ITER-1]} : trial[B_WIDTH:0];
        quo_d = {quo_q[ITER-2:0], ~trial[B_WIDTH+1]};
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StDone: begin
        if (ready_in) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= StIdle;
      quo_q   <= '0;
      rem_q   <= '0;
      div_q   <= '0;
      sign_q  <= 1'b0;
      dbz_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      dbz_q   <= dbz_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef FIXED_POINT_DIV_ROUND_EN
  // The last iteration produced the half bit; add it to round the magnitude away from zero.
  assign mag = {1'b0, quo_q[ITER-1:1]} + {{(ITER - 1){1'b0}}, quo_q[0]};
`else
  assign mag = quo_q;
`endif

  fixed_point_saturate #(
    .MAG_W   (ITER),
    .Q_WIDTH (Q_WIDTH)
  ) u_saturate (
    .mag      (mag),
    .neg      (sign_q),
    .q        (sat_q),
    .overflow (sat_ovf)
  );

  assign ready_out = (state_q == StIdle);
  assign valid_out = (state_q == StDone);

  // Outputs are forced to zero outside DONE so reset and idle both read as Q=0, flags=0.
  always_comb begin
    Q               = '0;
    div_by_zero_out = 1'b0;
    overflow_out    = 1'b0;
    if (valid_out) begin
      if (dbz_q) begin
        Q               = sign_q ? {1'b1, {(Q_WIDTH - 1){1'b0}}} : {1'b0, {(Q_WIDTH - 1){1'b1}}};
        div_by_zero_out = 1'b1;
      end else begin
        Q            = sat_q;
        overflow_out = sat_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_div_seq.sv
// Self-checking bench for fixed_point_div_seq: directed corner cases plus random operands.
module tb_fixed_point_div_seq;

  localparam int AW = 16;
  localparam int AF = 14;
  localparam int BW = 16;
  localparam int BF = 14;
  localparam int QW = 16;
  localparam int QF = 14;
  localparam int S  = QF + BF - AF;
  localparam int N  = AW + S;
`ifdef FIXED_POINT_DIV_ROUND_EN
  localparam bit ROUND = 1'b1;
`else
  localparam bit ROUND = 1'b0;
`endif
  localparam int LAT = N + 1 + int'(ROUND);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_in = 1'b0;
  logic          ready_in = 1'b1;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] b = '0;
  logic          ready_out;
  logic          valid_out;
  logic [QW-1:0] q;
  logic          dbz;
  logic          ovf;

  int total = 0;
  int bad   = 0;

  fixed_point_div_seq #(
    .A_WIDTH     (AW),
    .A_FRAC_BITS (AF),
    .B_WIDTH     (BW),
    .B_FRAC_BITS (BF),
    .Q_WIDTH     (QW),
    .Q_FRAC_BITS (QF)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst),
    .valid_in        (valid_in),
    .ready_out       (ready_out),
    .A               (a),
    .B               (b),
    .valid_out       (valid_out),
    .ready_in        (ready_in),
    .Q               (q),
    .div_by_zero_out (dbz),
    .overflow_out    (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: exact rational quotient of the real values, scaled to Q_FRAC_BITS.
  function automatic void model(input logic [AW-1:0] ai, input logic [BW-1:0] bi,
                                output logic [QW-1:0] eq, output logic ed, output logic eo);
    longint av, bv, am, bm, mag, lim;
    bit     neg;
    av = longint'($signed(ai));
    bv = longint'($signed(bi));
    am = (av < 0) ? -av : av;
    bm = (bv < 0) ? -bv : bv;
    ed = 1'b0;
    eo = 1'b0;
    if (bv == 0) begin
      ed = 1'b1;
      eq = (av < 0) ? 16'h8000 : 16'h7fff;
      return;
    end
    neg = (av < 0) != (bv < 0);
    if (ROUND) mag = ((am * (64'sd1 << (S + 1))) / bm + 1) / 2;
    else       mag = (am * (64'sd1 << S)) / bm;
    lim = neg ? 32768 : 32767;
    if (mag > lim) begin
      eo = 1'b1;
      eq = neg ? 16'h8000 : 16'h7fff;
    end else begin
      eq = 16'(neg ? -mag : mag);
    end
  endfunction

  task automatic run_op(input logic [AW-1:0] ai, input logic [BW-1:0] bi, input int hold,
                        input string tag);
    logic [QW-1:0] eq;
    logic          ed, eo;
    int            k;
    model(ai, bi, eq, ed, eo);
    k = 0;
    while (!ready_out && k < 100) begin
      tick();
      k++;
    end
    valid_in = 1'b1;
    a        = ai;
    b        = bi;
    ready_in = (hold == 0);
    tick();
    valid_in = 1'b0;
    a        = AW'($urandom);
    b        = BW'($urandom);
    k        = 1;
    while (!valid_out && k < LAT + 10) begin
      tick();
      k++;
    end
    check({tag, " latency"}, k, (bi == '0) ? 1 : LAT);
    check({tag, " q"}, longint'(q), longint'(eq));
    check({tag, " dbz"}, longint'(dbz), longint'(ed));
    check({tag, " ovf"}, longint'(ovf), longint'(eo));
    if (hold > 0) begin
      repeat (hold) begin
        valid_in = 1'b1;
        a        = AW'($urandom);
        b        = BW'($urandom);
        tick();
      end
      valid_in = 1'b0;
      check({tag, " hold valid"}, longint'(valid_out), 1);
      check({tag, " hold ready"}, longint'(ready_out), 0);
      check({tag, " hold q"}, longint'(q), longint'(eq));
      check({tag, " hold flags"}, longint'({dbz, ovf}), longint'({ed, eo}));
      ready_in = 1'b1;
    end
    tick();
    check({tag, " release valid"}, longint'(valid_out), 0);
    check({tag, " release ready"}, longint'(ready_out), 1);
  endtask

  initial begin
    int seen;
    logic [AW-1:0] ra;
    logic [BW-1:0] rb;

    rst = 1'b1;
    repeat (3) tick();
    check("reset ready", longint'(ready_out), 1);
    check("reset valid", longint'(valid_out), 0);
    check("reset q", longint'(q), 0);
    check("reset dbz", longint'(dbz), 0);
    check("reset ovf", longint'(ovf), 0);
    rst = 1'b0;
    tick();

    run_op(16'd8192, 16'd16384, 0, "half");
    run_op(16'he000, 16'd16384, 0, "neg half");
    run_op(16'h8000, 16'hc000, 0, "sat pos");
    run_op(16'h8000, 16'd16384, 0, "most neg exact");
    run_op(16'd2, 16'd3, 0, "two thirds");
    run_op(16'd100, 16'd0, 0, "dbz pos");
    run_op(16'hff9c, 16'd0, 0, "dbz neg");
    run_op(16'h1234, 16'h0456, 3, "hold");
    run_op(16'hfc00, 16'd0, 2, "dbz hold");

    // Abort mid-division: the operation must vanish without a result.
    valid_in = 1'b1;
    a        = 16'd8192;
    b        = 16'd16384;
    tick();
    valid_in = 1'b0;
    repeat (10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort ready", longint'(ready_out), 1);
    check("abort valid", longint'(valid_out), 0);
    check("abort q", longint'(q), 0);
    seen = 0;
    repeat (N + 5) begin
      if (valid_out) seen++;
      tick();
    end
    check("abort no result", seen, 0);

    for (int i = 0; i < 40; i++) begin
      ra = AW'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1, 2, 3: rb = BW'($urandom_range(1, 600)) ^ {BW{ra[0]}};
        default: rb = BW'($urandom);
      endcase
      run_op(ra, rb, int'($urandom_range(0, 2)), "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
